// File: rtl/first_filter_cfg_ctrl_pkg.sv
// Shared match-table geometry, packet-bus widths and config FSM state encoding
// for first_filter and its table-update controller.
package first_filter_cfg_ctrl_pkg;

    localparam int MT_AWIDTH    = 13;
    localparam int MT_DWIDTH    = 64;
    localparam int MT_DEPTH_DEF = 8192;
    localparam int FP_DWIDTH    = 64;
    localparam int FP_EWIDTH    = 3;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HOLD  = 3'd1,
        DRAIN = 3'd2,
        WRITE = 3'd3,
        FILL  = 3'd4,
        GAP   = 3'd5
    } ff_cfg_state_t;

endpackage

// File: rtl/first_filter_cfg_ctrl.sv
// Closes the packet stream at a packet boundary, lets the filter read pipeline
// drain, then steals the match-table write port for single writes or sweep fills.
module first_filter_cfg_ctrl
    import first_filter_cfg_ctrl_pkg::*;
#(
    parameter int DRAIN_CYCLES = 4,
    parameter int MAX_WR_BURST = 16,
    parameter int MT_DEPTH     = MT_DEPTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [FP_DWIDTH-1:0] s_data,
    input  logic                 s_valid,
    input  logic                 s_sop,
    input  logic                 s_eop,
    input  logic [FP_EWIDTH-1:0] s_empty,
    output logic                 s_ready,
    output logic [FP_DWIDTH-1:0] f_data,
    output logic                 f_valid,
    output logic                 f_sop,
    output logic                 f_eop,
    output logic [FP_EWIDTH-1:0] f_empty,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic                 cfg_fill,
    input  logic [MT_AWIDTH-1:0] cfg_addr,
    input  logic [MT_DWIDTH-1:0] cfg_data,
    output logic                 f_wr_en,
    output logic [MT_AWIDTH-1:0] f_wr_addr,
    output logic [MT_DWIDTH-1:0] f_wr_data,
    output logic                 busy,
    output logic                 fill_done
);

    localparam int DCW = $clog2(DRAIN_CYCLES + 1);
    localparam int BCW = $clog2(MAX_WR_BURST + 1);
    localparam logic [MT_AWIDTH-1:0] LAST_ADDR = MT_AWIDTH'(MT_DEPTH - 1);
    localparam logic [BCW-1:0]       BURST_MAX = BCW'(MAX_WR_BURST);

    ff_cfg_state_t        state_q, state_d;
    logic                 in_pkt_q, in_pkt_d;
    logic [DCW-1:0]       drain_cnt_q, drain_cnt_d;
    logic [BCW-1:0]       burst_cnt_q, burst_cnt_d;
    logic [MT_AWIDTH-1:0] fill_addr_q, fill_addr_d;
    logic [MT_DWIDTH-1:0] fill_data_q, fill_data_d;
    logic                 wr_en_q, wr_en_d;
    logic [MT_AWIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [MT_DWIDTH-1:0] wr_data_q, wr_data_d;
    logic                 fill_done_q, fill_done_d;
    logic                 wr_exit;
    logic                 cfg_acc;

    // Stream gating depends only on registered state so s_ready has no input path.
    assign s_ready = (state_q == IDLE) || ((state_q == HOLD) && in_pkt_q);
    assign f_valid = s_valid & s_ready;
    assign f_data  = s_data;
    assign f_sop   = s_sop;
    assign f_eop   = s_eop;
    assign f_empty = s_empty;

    // Leave the write window when the host goes quiet, or when the burst quota is spent
    // and a packet is waiting.
    assign wr_exit   = !cfg_valid || ((burst_cnt_q == BURST_MAX) && s_valid);
    assign cfg_ready = (state_q == WRITE) && !wr_exit;
    assign cfg_acc   = cfg_valid && cfg_ready;

    assign f_wr_en   = wr_en_q;
    assign f_wr_addr = wr_addr_q;
    assign f_wr_data = wr_data_q;
    assign busy      = (state_q != IDLE);
    assign fill_done = fill_done_q;

    always_comb begin
        state_d     = state_q;
        in_pkt_d    = in_pkt_q;
        drain_cnt_d = drain_cnt_q;
        burst_cnt_d = burst_cnt_q;
        fill_addr_d = fill_addr_q;
        fill_data_d = fill_data_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        fill_done_d = 1'b0;

        if (f_valid) begin
            if (s_eop) begin
                in_pkt_d = 1'b0;
            end else if (s_sop) begin
                in_pkt_d = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (cfg_valid) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (!in_pkt_q) begin
                    drain_cnt_d = DCW'(DRAIN_CYCLES - 1);
                    state_d     = DRAIN;
                end
            end
            DRAIN: begin
                drain_cnt_d = drain_cnt_q - DCW'(1);
                if (drain_cnt_q <= DCW'(1)) begin
                    burst_cnt_d = '0;
                    state_d     = WRITE;
                end
            end
            WRITE: begin
                if (cfg_acc) begin
                    // Saturate so an uncapped run still trips the quota once traffic appears.
                    if (burst_cnt_q < BURST_MAX) begin
                        burst_cnt_d = burst_cnt_q + BCW'(1);
                    end
                    if (cfg_fill) begin
                        fill_addr_d = cfg_addr;
                        fill_data_d = cfg_data;
                        state_d     = FILL;
                    end else begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = cfg_addr;
                        wr_data_d = cfg_data;
                    end
                end else begin
                    state_d = GAP;
                end
            end
            FILL: begin
                wr_en_d   = 1'b1;
                wr_addr_d = fill_addr_q;
                wr_data_d = fill_data_q;
                if (fill_addr_q >= LAST_ADDR) begin
                    fill_done_d = 1'b1;
                    state_d     = WRITE;
                end else begin
                    fill_addr_d = fill_addr_q + MT_AWIDTH'(1);
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            in_pkt_q    <= 1'b0;
            drain_cnt_q <= '0;
            burst_cnt_q <= '0;
            fill_addr_q <= '0;
            fill_data_q <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            fill_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_pkt_q    <= in_pkt_d;
            drain_cnt_q <= drain_cnt_d;
            burst_cnt_q <= burst_cnt_d;
            fill_addr_q <= fill_addr_d;
            fill_data_q <= fill_data_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            fill_done_q <= fill_done_d;
        end
    end

endmodule

// File: tb/tb_first_filter_cfg_ctrl.sv
// Bench for first_filter_cfg_ctrl: pass-through vector table, write scoreboard,
// and hand sequences for drain latency, mid-packet hold, fill end, burst cap and reset.
module tb_first_filter_cfg_ctrl;
    import first_filter_cfg_ctrl_pkg::*;

    localparam int DRAIN_CYCLES = 4;
    localparam int MAX_WR_BURST = 16;
    localparam int MT_DEPTH     = 8192;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [FP_DWIDTH-1:0] s_data;
    logic                 s_valid, s_sop, s_eop;
    logic [FP_EWIDTH-1:0] s_empty;
    logic                 s_ready;
    logic [FP_DWIDTH-1:0] f_data;
    logic                 f_valid, f_sop, f_eop;
    logic [FP_EWIDTH-1:0] f_empty;
    logic                 cfg_valid, cfg_ready, cfg_fill;
    logic [MT_AWIDTH-1:0] cfg_addr;
    logic [MT_DWIDTH-1:0] cfg_data;
    logic                 f_wr_en;
    logic [MT_AWIDTH-1:0] f_wr_addr;
    logic [MT_DWIDTH-1:0] f_wr_data;
    logic                 busy, fill_done;

    first_filter_cfg_ctrl #(
        .DRAIN_CYCLES(DRAIN_CYCLES),
        .MAX_WR_BURST(MAX_WR_BURST),
        .MT_DEPTH    (MT_DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .s_data(s_data), .s_valid(s_valid), .s_sop(s_sop), .s_eop(s_eop),
        .s_empty(s_empty), .s_ready(s_ready),
        .f_data(f_data), .f_valid(f_valid), .f_sop(f_sop), .f_eop(f_eop),
        .f_empty(f_empty),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_fill(cfg_fill),
        .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .f_wr_en(f_wr_en), .f_wr_addr(f_wr_addr), .f_wr_data(f_wr_data),
        .busy(busy), .fill_done(fill_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [MT_AWIDTH-1:0] addr;
        logic [MT_DWIDTH-1:0] data;
        logic                 last;
    } wr_exp_t;

    typedef struct packed {
        logic                 valid;
        logic                 sop;
        logic                 eop;
        logic [FP_EWIDTH-1:0] empty;
        logic [FP_DWIDTH-1:0] data;
        logic                 exp_fvalid;
        logic                 exp_busy;
    } vec_t;

    wr_exp_t sbq[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int wr_seen = 0;
    int last_wr_cyc = -1;
    int first_wr_cyc = -1;
    int last_fv_cyc = -100;
    int ready_cnt = 0;
    int fd_cnt = 0;

    logic                 cmd_fill[32];
    logic [MT_AWIDTH-1:0] cmd_addr[32];
    logic [MT_DWIDTH-1:0] cmd_data[32];

    logic [FP_DWIDTH-1:0] bt_data[8];
    logic                 bt_sop[8];
    logic                 bt_eop[8];
    logic [FP_EWIDTH-1:0] bt_empty[8];
    int                   acc_cyc[8];
    int                   pkt_acc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Write scoreboard and per-cycle invariants, sampled mid-cycle.
    initial begin
        wr_exp_t e;
        forever begin
            @(negedge clk);
            if (f_wr_en) begin
                wr_seen++;
                last_wr_cyc = cyc;
                if (first_wr_cyc < 0) first_wr_cyc = cyc;
                $display("WR   cyc=%0d addr=0x%04h data=0x%016h fill_done=%0b", cyc, f_wr_addr, f_wr_data, fill_done);
                chk("wr_after_beat", 64'(cyc - last_fv_cyc > DRAIN_CYCLES), 64'd1);
                if (sbq.size() == 0) begin
                    chk("wr_unexpected", 64'(f_wr_addr), 64'hFFFF_FFFF);
                end else begin
                    e = sbq.pop_front();
                    chk("wr_addr", 64'(f_wr_addr), 64'(e.addr));
                    chk("wr_data", f_wr_data, e.data);
                    chk("fill_done_on_last", 64'(fill_done), 64'(e.last));
                end
            end else begin
                chk("fill_done_idle", 64'(fill_done), 64'd0);
            end
            if (fill_done) fd_cnt++;
            if (cfg_ready) ready_cnt++;
            if (f_valid) begin
                last_fv_cyc = cyc;
                $display("BEAT cyc=%0d data=0x%016h sop=%0b eop=%0b empty=%0d", cyc, f_data, f_sop, f_eop, f_empty);
            end
            if (rst) begin
                sbq.delete();
            end else if (cfg_valid && cfg_ready) begin
                $display("CMD  cyc=%0d fill=%0b addr=0x%04h data=0x%016h", cyc, cfg_fill, cfg_addr, cfg_data);
                if (cfg_fill) begin
                    for (int a = int'(cfg_addr); a < MT_DEPTH; a++) begin
                        e.addr = MT_AWIDTH'(a);
                        e.data = cfg_data;
                        e.last = (a == MT_DEPTH - 1);
                        sbq.push_back(e);
                    end
                end else begin
                    e.addr = cfg_addr;
                    e.data = cfg_data;
                    e.last = 1'b0;
                    sbq.push_back(e);
                end
            end
        end
    end

    // Called just after a rising edge; returns once all n commands were accepted.
    task automatic run_cmds(input int n, input int budget);
        int idx = 0;
        int k = 0;
        cfg_valid = 1'b1;
        cfg_fill  = cmd_fill[0];
        cfg_addr  = cmd_addr[0];
        cfg_data  = cmd_data[0];
        while (idx < n && k < budget) begin
            @(negedge clk);
            if (cfg_valid && cfg_ready) idx++;
            @(posedge clk);
            #1;
            k++;
            if (idx < n) begin
                cfg_fill = cmd_fill[idx];
                cfg_addr = cmd_addr[idx];
                cfg_data = cmd_data[idx];
            end else begin
                cfg_valid = 1'b0;
            end
        end
        cfg_valid = 1'b0;
        chk("cmds_accepted", 64'(idx), 64'(n));
    endtask

    task automatic send_beats(input int n, input int budget);
        int k = 0;
        pkt_acc = 0;
        while (pkt_acc < n && k < budget) begin
            s_valid = 1'b1;
            s_data  = bt_data[pkt_acc];
            s_sop   = bt_sop[pkt_acc];
            s_eop   = bt_eop[pkt_acc];
            s_empty = bt_empty[pkt_acc];
            @(negedge clk);
            if (s_valid && s_ready) begin
                acc_cyc[pkt_acc] = cyc;
                pkt_acc++;
            end
            @(posedge clk);
            #1;
            k++;
        end
        s_valid = 1'b0;
        chk("beats_accepted", 64'(pkt_acc), 64'(n));
    endtask

    task automatic wait_quiet(input string name);
        int k = 0;
        while ((busy || sbq.size() != 0) && k < 10000) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk(name, 64'(busy || sbq.size() != 0), 64'd0);
    endtask

    initial begin
        vec_t vecs[5];
        int wr_base;
        int fd_base;
        int c0;
        int mark;
        int pkt_ok;

        rst = 1'b1;
        s_data = '0; s_valid = 1'b0; s_sop = 1'b0; s_eop = 1'b0; s_empty = '0;
        cfg_valid = 1'b0; cfg_fill = 1'b0; cfg_addr = '0; cfg_data = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_s_ready", 64'(s_ready), 64'd1);
        chk("rst_cfg_ready", 64'(cfg_ready), 64'd0);
        chk("rst_wr", {50'd0, f_wr_en, f_wr_addr}, 64'd0);
        chk("rst_wr_data", f_wr_data, 64'd0);
        chk("rst_busy_fd", {62'd0, busy, fill_done}, 64'd0);
        rst = 1'b0;

        // Idle host: packet forwarded combinationally and unchanged.
        vecs[0] = '{1'b1, 1'b1, 1'b0, 3'd0, 64'hA0A0_0000_0000_0001, 1'b1, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 3'd0, 64'hA0A0_0000_0000_0002, 1'b1, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 1'b1, 3'd5, 64'hA0A0_0000_0000_0003, 1'b1, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 1'b0, 3'd0, 64'h0000_0000_0000_0000, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 1'b1, 1'b1, 3'd2, 64'h5A5A_1234_5678_9ABC, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            s_valid = vecs[i].valid; s_sop = vecs[i].sop; s_eop = vecs[i].eop;
            s_empty = vecs[i].empty; s_data = vecs[i].data;
            #1;
            chk("pt_f_valid", 64'(f_valid), 64'(vecs[i].exp_fvalid));
            chk("pt_s_ready", 64'(s_ready), 64'd1);
            chk("pt_busy", 64'(busy), 64'(vecs[i].exp_busy));
            if (vecs[i].exp_fvalid) begin
                chk("pt_f_data", f_data, vecs[i].data);
                chk("pt_ctrl", {59'd0, f_sop, f_eop, f_empty}, {59'd0, vecs[i].sop, vecs[i].eop, vecs[i].empty});
            end
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;

        // Single write with no traffic: first write DRAIN_CYCLES+2 cycles after cfg_valid.
        wr_base = wr_seen; ready_cnt = 0; first_wr_cyc = -1;
        cmd_fill[0] = 1'b0; cmd_addr[0] = 13'h0123; cmd_data[0] = 64'hFFFF_0000_FFFF_0000;
        @(posedge clk);
        #1;
        c0 = cyc;
        run_cmds(1, 50);
        wait_quiet("single_quiet");
        chk("single_latency", 64'(first_wr_cyc - c0), 64'(DRAIN_CYCLES + 2));
        chk("single_wr_count", 64'(wr_seen - wr_base), 64'd1);
        chk("single_ready_cycles", 64'(ready_cnt), 64'd1);

        // cfg_valid raised on beat 2 of 5; a following single-beat packet waits for GAP.
        for (int i = 0; i < 6; i++) begin
            bt_data[i]  = 64'hC0DE_0000_0000_0000 | 64'(i);
            bt_sop[i]   = (i == 0) || (i == 5);
            bt_eop[i]   = (i == 4) || (i == 5);
            bt_empty[i] = (i == 4) ? 3'd1 : 3'd0;
        end
        wr_base = wr_seen;
        cmd_fill[0] = 1'b0; cmd_addr[0] = 13'h0777; cmd_data[0] = 64'h0123_4567_89AB_CDEF;
        @(posedge clk);
        #1;
        fork
            send_beats(6, 200);
            begin
                for (int k = 0; k < 50 && pkt_acc < 1; k++) begin
                    @(posedge clk);
                    #1;
                end
                run_cmds(1, 100);
            end
        join
        wait_quiet("midpkt_quiet");
        chk("midpkt_wr_count", 64'(wr_seen - wr_base), 64'd1);
        chk("midpkt_tail_back2back", 64'(acc_cyc[4] - acc_cyc[1]), 64'd3);
        chk("midpkt_drain_gap", 64'(last_wr_cyc - acc_cyc[4] > DRAIN_CYCLES), 64'd1);
        chk("midpkt_sop_after_gap", 64'(acc_cyc[5] - last_wr_cyc), 64'd2);

        // Fill near the top: two writes, fill_done on the second, then the next command.
        wr_base = wr_seen; fd_base = fd_cnt;
        cmd_fill[0] = 1'b1; cmd_addr[0] = 13'd8190; cmd_data[0] = '1;
        cmd_fill[1] = 1'b0; cmd_addr[1] = 13'd5;    cmd_data[1] = 64'h55;
        @(posedge clk);
        #1;
        run_cmds(2, 100);
        wait_quiet("fill_quiet");
        chk("fill_wr_count", 64'(wr_seen - wr_base), 64'd3);
        chk("fill_done_count", 64'(fd_cnt - fd_base), 64'd1);

        // Burst cap: 20 queued writes against a waiting packet.
        for (int i = 0; i < 20; i++) begin
            cmd_fill[i] = 1'b0;
            cmd_addr[i] = MT_AWIDTH'(13'h0200 + i);
            cmd_data[i] = 64'hB000_0000_0000_0000 | 64'(i * 3 + 1);
        end
        wr_base = wr_seen; mark = -1; pkt_ok = 0;
        @(posedge clk);
        #1;
        fork
            run_cmds(20, 400);
            begin
                for (int k = 0; k < 50 && !busy; k++) begin
                    @(posedge clk);
                    #1;
                end
                s_valid = 1'b1; s_sop = 1'b1; s_eop = 1'b1; s_empty = 3'd0;
                s_data = 64'hFACE_FACE_FACE_FACE;
                for (int k = 0; k < 400 && pkt_ok == 0; k++) begin
                    @(negedge clk);
                    if (s_valid && s_ready) begin
                        mark = wr_seen - wr_base;
                        pkt_ok = 1;
                    end
                    @(posedge clk);
                    #1;
                end
                s_valid = 1'b0;
            end
        join
        wait_quiet("burst_quiet");
        chk("burst_pkt_accepted", 64'(pkt_ok), 64'd1);
        chk("burst_writes_before_pkt", 64'(mark), 64'(MAX_WR_BURST));
        chk("burst_wr_total", 64'(wr_seen - wr_base), 64'd20);

        // Reset in the middle of a fill aborts it immediately.
        cmd_fill[0] = 1'b1; cmd_addr[0] = 13'd100; cmd_data[0] = 64'hDEAD_BEEF_0000_0064;
        @(posedge clk);
        #1;
        run_cmds(1, 50);
        mark = 0;
        for (int k = 0; k < 200 && mark == 0; k++) begin
            @(negedge clk);
            if (f_wr_en && f_wr_addr == 13'd110) mark = 1;
        end
        chk("rstfill_reached", 64'(mark), 64'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rstfill_wr_en", 64'(f_wr_en), 64'd0);
        chk("rstfill_busy", 64'(busy), 64'd0);
        chk("rstfill_s_ready", 64'(s_ready), 64'd1);
        rst = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("rstfill_stays_idle", {62'd0, f_wr_en, busy}, 64'd0);
        wait_quiet("rstfill_quiet");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
